// File: rtl/microseq_control.sv
// Microcode sequencer: a writable {flags, opcode, step} indexed table drives a
// registered control word, with early end-of-instruction, halt/resume and run gating.
module microseq_control #(
  parameter int OP_W      = 4,
  parameter int STEP_W    = 3,
  parameter int MAX_STEPS = 5,
  parameter int FLAG_W    = 2,
  parameter int CW        = 16,
  parameter int HLT_BIT   = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            run,
  input  logic                            resume,
  input  logic [FLAG_W-1:0]               flags,
  input  logic [OP_W-1:0]                 instruction,
  input  logic                            ucode_we,
  input  logic [FLAG_W+OP_W+STEP_W-1:0]   ucode_addr,
  input  logic [CW:0]                     ucode_wdata,
  output logic [CW-1:0]                   ctrl_data,
  output logic [STEP_W-1:0]               step,
  output logic                            busy,
  output logic                            halted
);

  localparam int AW    = FLAG_W + OP_W + STEP_W;
  localparam int DEPTH = 1 << AW;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);
  localparam logic [CW-1:0]     HALT_WORD = {{(CW-1){1'b0}}, 1'b1} << HLT_BIT;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [CW-1:0]       ctrl_q;
  logic                busy_q;
  logic                halted_q;
  logic [CW:0]         table_q [DEPTH];
  logic [CW:0]         entry_d;
  logic                wrap_d;

  // Microword lookup and end-of-instruction detection for the current step
  always_comb begin
    entry_d = table_q[{flags, instruction, step_q}];
    if (entry_d[CW] || (step_q == LAST_STEP)) begin
      wrap_d = 1'b1;
    end else begin
      wrap_d = 1'b0;
    end
  end

  // Microcode store: survives reset, writable only while not executing
  always_ff @(posedge clk) begin
    if (ucode_we && (state_q != S_RUN)) begin
      table_q[ucode_addr] <= ucode_wdata;
    end
  end

  // Sequencer FSM with registered control word and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= {STEP_W{1'b0}};
      ctrl_q   <= {CW{1'b0}};
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ctrl_q <= {CW{1'b0}};
          step_q <= {STEP_W{1'b0}};
          if (run) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          ctrl_q <= entry_d[CW-1:0];
          // Halt wins over EOI so a halting word never falls through to IDLE
          if (entry_d[HLT_BIT]) begin
            state_q  <= S_HALTED;
            step_q   <= {STEP_W{1'b0}};
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else if (wrap_d) begin
            step_q <= {STEP_W{1'b0}};
            if (!run) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              busy_q  <= 1'b1;
            end
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        S_HALTED: begin
          step_q <= {STEP_W{1'b0}};
          if (resume) begin
            state_q  <= S_RUN;
            ctrl_q   <= {CW{1'b0}};
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end else begin
            ctrl_q   <= HALT_WORD;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          step_q   <= {STEP_W{1'b0}};
          ctrl_q   <= {CW{1'b0}};
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_data = ctrl_q;
  assign step      = step_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_microseq_control.sv
// Directed self-checking bench for microseq_control: LDA, early EOI, conditional
// jump, halt/resume, write protection, run drop and asynchronous reset.
module tb_microseq_control;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        resume;
  logic [1:0]  flags;
  logic [3:0]  instruction;
  logic        ucode_we;
  logic [8:0]  ucode_addr;
  logic [16:0] ucode_wdata;
  logic [15:0] ctrl_data;
  logic [2:0]  step;
  logic        busy;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  microseq_control dut (
    .clk(clk), .rst_n(rst_n), .run(run), .resume(resume), .flags(flags),
    .instruction(instruction), .ucode_we(ucode_we), .ucode_addr(ucode_addr),
    .ucode_wdata(ucode_wdata), .ctrl_data(ctrl_data), .step(step),
    .busy(busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] f, input logic [3:0] op, input logic [2:0] s,
                    input logic [16:0] d);
    ucode_addr  = {f, op, s};
    ucode_wdata = d;
    ucode_we    = 1'b1;
    tick();
    ucode_we    = 1'b0;
  endtask

  task automatic load_op(input logic [3:0] op, input logic [16:0] w0, input logic [16:0] w1,
                         input logic [16:0] w2, input logic [16:0] w3, input logic [16:0] w4);
    for (int f = 0; f < 4; f++) begin
      wr(2'(f), op, 3'd0, w0);
      wr(2'(f), op, 3'd1, w1);
      wr(2'(f), op, 3'd2, w2);
      wr(2'(f), op, 3'd3, w3);
      wr(2'(f), op, 3'd4, w4);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b0; resume = 1'b0; flags = 2'b00; instruction = 4'h0;
    ucode_we = 1'b0; ucode_addr = 9'd0; ucode_wdata = 17'd0;
    #12;
    n_checks++; if (ctrl_data !== 16'h0000) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0000", ctrl_data); end
    n_checks++; if (step !== 3'd0) begin n_fail++; $display("FAIL reset_step: got %0d expected 0", step); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_program;
    load_op(4'h1, 17'h04004, 17'h01408, 17'h00A00, 17'h01200, 17'h00000);
    load_op(4'h0, 17'h04004, 17'h01408, 17'h10000, 17'h00000, 17'h00000);
    load_op(4'h7, 17'h04004, 17'h01408, 17'h10000, 17'h00000, 17'h00000);
    wr(2'b01, 4'h7, 3'd2, 17'h10802);
    wr(2'b11, 4'h7, 3'd2, 17'h10802);
    load_op(4'hF, 17'h04004, 17'h01408, 17'h08000, 17'h00000, 17'h00000);
    n_checks++; if (ctrl_data !== 16'h0000) begin n_fail++; $display("FAIL idle_load_ctrl: got %h expected 0000", ctrl_data); end
  endtask

  task automatic test_lda;
    logic [15:0] exp_c [6] = '{16'h4004, 16'h1408, 16'h0A00, 16'h1200, 16'h0000, 16'h4004};
    logic [2:0]  exp_s [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    instruction = 4'h1; flags = 2'b00; run = 1'b1;
    tick();
    n_checks++; if (ctrl_data !== 16'h0000) begin n_fail++; $display("FAIL lda_start_ctrl: got %h expected 0000", ctrl_data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lda_start_busy: got %b expected 1", busy); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (ctrl_data !== exp_c[i]) begin n_fail++; $display("FAIL lda_ctrl[%0d]: got %h expected %h", i, ctrl_data, exp_c[i]); end
      n_checks++; if (step !== exp_s[i]) begin n_fail++; $display("FAIL lda_step[%0d]: got %0d expected %0d", i, step, exp_s[i]); end
    end
  endtask

  task automatic test_run_drop;
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy_mid[%0d]: got %b expected 1", i, busy); end
    end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy_end: got %b expected 0", busy); end
    n_checks++; if (step !== 3'd0) begin n_fail++; $display("FAIL drop_step_end: got %0d expected 0", step); end
    tick();
    n_checks++; if (ctrl_data !== 16'h0000) begin n_fail++; $display("FAIL drop_idle_ctrl: got %h expected 0000", ctrl_data); end
  endtask

  task automatic test_early_eoi;
    logic [15:0] exp_c [6] = '{16'h4004, 16'h1408, 16'h0000, 16'h4004, 16'h1408, 16'h0000};
    logic [2:0]  exp_s [6] = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    logic        exp_b [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    instruction = 4'h0; run = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) run = 1'b0;
      tick();
      n_checks++; if (ctrl_data !== exp_c[i]) begin n_fail++; $display("FAIL eoi_ctrl[%0d]: got %h expected %h", i, ctrl_data, exp_c[i]); end
      n_checks++; if (step !== exp_s[i]) begin n_fail++; $display("FAIL eoi_step[%0d]: got %0d expected %0d", i, step, exp_s[i]); end
      n_checks++; if (busy !== exp_b[i]) begin n_fail++; $display("FAIL eoi_busy[%0d]: got %b expected %b", i, busy, exp_b[i]); end
    end
  endtask

  task automatic test_jc;
    logic [1:0]  fl [4]  = '{2'b01, 2'b00, 2'b11, 2'b10};
    logic [15:0] exp [4] = '{16'h0802, 16'h0000, 16'h0802, 16'h0000};
    instruction = 4'h7; run = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      flags = fl[i];
      tick();
      n_checks++; if (ctrl_data !== 16'h4004) begin n_fail++; $display("FAIL jc_fetch[%0d]: got %h expected 4004", i, ctrl_data); end
      tick();
      if (i == 3) run = 1'b0;
      tick();
      n_checks++; if (ctrl_data !== exp[i]) begin n_fail++; $display("FAIL jc_word[flags=%b]: got %h expected %h", fl[i], ctrl_data, exp[i]); end
      n_checks++; if (step !== 3'd0) begin n_fail++; $display("FAIL jc_step[%0d]: got %0d expected 0", i, step); end
    end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL jc_idle_busy: got %b expected 0", busy); end
    flags = 2'b00;
  endtask

  task automatic test_halt_resume;
    instruction = 4'hF; run = 1'b1;
    tick();
    // attempt to erase the halt word while running
    ucode_addr = {2'b00, 4'hF, 3'd2}; ucode_wdata = 17'h00000; ucode_we = 1'b1;
    tick();
    ucode_we = 1'b0;
    n_checks++; if (ctrl_data !== 16'h4004) begin n_fail++; $display("FAIL halt_fetch: got %h expected 4004", ctrl_data); end
    tick();
    tick();
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_protect: got halted=%b expected 1", halted); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL halt_busy: got %b expected 0", busy); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (ctrl_data !== 16'h8000 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold[%0d]: got ctrl=%h halted=%b expected 8000/1", i, ctrl_data, halted); end
    end
    wr(2'b00, 4'hF, 3'd0, 17'h04006);
    n_checks++; if (ctrl_data !== 16'h8000) begin n_fail++; $display("FAIL halt_write_ctrl: got %h expected 8000", ctrl_data); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    n_checks++; if (ctrl_data !== 16'h0000 || step !== 3'd0) begin n_fail++; $display("FAIL resume_ctrl: got ctrl=%h step=%0d expected 0000/0", ctrl_data, step); end
    n_checks++; if (busy !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("FAIL resume_state: got busy=%b halted=%b expected 1/0", busy, halted); end
    tick();
    n_checks++; if (ctrl_data !== 16'h4006 || step !== 3'd1) begin n_fail++; $display("FAIL resume_fetch: got ctrl=%h step=%0d expected 4006/1", ctrl_data, step); end
    tick();
    tick();
    n_checks++; if (halted !== 1'b1 || ctrl_data !== 16'h8000) begin n_fail++; $display("FAIL rehalt: got halted=%b ctrl=%h expected 1/8000", halted, ctrl_data); end
    wr(2'b00, 4'hF, 3'd0, 17'h04004);
  endtask

  task automatic test_reset_mid_run;
    instruction = 4'h1; run = 1'b1; resume = 1'b1;
    tick();
    resume = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (step !== 3'd3 || ctrl_data !== 16'h0A00) begin n_fail++; $display("FAIL pre_reset: got step=%0d ctrl=%h expected 3/0a00", step, ctrl_data); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (ctrl_data !== 16'h0000) begin n_fail++; $display("FAIL async_reset_ctrl: got %h expected 0000", ctrl_data); end
    n_checks++; if (step !== 3'd0) begin n_fail++; $display("FAIL async_reset_step: got %0d expected 0", step); end
    n_checks++; if (busy !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL async_reset_status: got busy=%b halted=%b expected 0/0", busy, halted); end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (ctrl_data !== 16'h0000 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got ctrl=%h busy=%b expected 0000/0", ctrl_data, busy); end
    run = 1'b1;
    tick();
    tick();
    n_checks++; if (ctrl_data !== 16'h4004) begin n_fail++; $display("FAIL table_kept: got %h expected 4004", ctrl_data); end
    run = 1'b0;
    for (int i = 0; i < 10 && busy === 1'b1; i++) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL final_drain: got busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    load_program();
    test_lda();
    test_run_drop();
    test_early_eoi();
    test_jc();
    test_halt_resume();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
